fish_game_sequencer: RTL

//  Round/level sequencer for the fishing game. Generates the slow game tick, runs the per-level

---
 rtl/fish_game_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/fish_game_sequencer.sv
// Fishing-game round/level sequencer: game tick divider, per-level countdown, level advance, scoring, win/lose.
// Every output is registered and reflects an input one cycle later; the block never stalls or applies backpressure to its inputs.
module fish_game_sequencer #(
  parameter int TICK_DIV    = 500000,
  parameter int ROUND_TICKS = 1800,
  parameter int NUM_LEVELS  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        caught,
  input  logic        landed,
  output logic        tick,
  output logic [2:0]  phase,
  output logic [1:0]  level,
  output logic [11:0] time_left,
  output logic [7:0]  score,
  output logic        game_over
);

  localparam int              DW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [DW-1:0]   DIV_PRE  = DW'(TICK_DIV - 2);
  localparam logic [11:0]     RELOAD   = 12'(ROUND_TICKS);
  localparam logic [1:0]      LAST_LVL = 2'(NUM_LEVELS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FISHING = 3'd1,
    REELING = 3'd2,
    WIN     = 3'd3,
    LOSE    = 3'd4
  } phase_t;

  phase_t        r_phase;
  logic [DW-1:0] r_div;
  logic          r_tick;
  logic [1:0]    r_level;
  logic [11:0]   r_time;
  logic [7:0]    r_score;
  logic          r_game_over;

  logic [5:0]    w_gain;
  logic [8:0]    w_sum;
  logic [7:0]    w_score_sat;

  // Landing bonus: 4 per level number (1-based) plus the coarse time remaining.
  assign w_gain      = {2'b00, r_level, 2'b00} + 6'd4 + {2'b00, r_time[11:8]};
  assign w_sum       = {1'b0, r_score} + {3'b000, w_gain};
  assign w_score_sat = w_sum[8] ? 8'hFF : w_sum[7:0];

  // Tick is registered one count early so it is high exactly while the count sits at its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_div == DIV_PRE);
      if (r_div == DIV_LAST) r_div <= '0;
      else                   r_div <= r_div + DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase     <= IDLE;
      r_level     <= 2'd0;
      r_time      <= RELOAD;
      r_score     <= 8'd0;
      r_game_over <= 1'b0;
    end else if (start) begin
      r_phase     <= FISHING;
      r_level     <= 2'd0;
      r_time      <= RELOAD;
      r_score     <= 8'd0;
      r_game_over <= 1'b0;
    end else begin
      case (r_phase)
        FISHING: begin
          if (caught) begin
            r_phase <= REELING;
          end else if (r_tick) begin
            if (r_time <= 12'd1) begin
              r_time      <= 12'd0;
              r_phase     <= LOSE;
              r_game_over <= 1'b1;
            end else begin
              r_time <= r_time - 12'd1;
            end
          end
        end
        REELING: begin
          if (landed) begin
            r_score <= w_score_sat;
            if (r_level == LAST_LVL) begin
              r_phase     <= WIN;
              r_game_over <= 1'b1;
            end else begin
              r_level <= r_level + 2'd1;
              r_time  <= RELOAD;
              r_phase <= FISHING;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign tick      = r_tick;
  assign phase     = r_phase;
  assign level     = r_level;
  assign time_left = r_time;
  assign score     = r_score;
  assign game_over = r_game_over;

endmodule
